// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: register-field width, FSM states, control bundle.
package hazard_ctrl_pkg;
  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } state_e;

  // Write-enables and flushes for the pipeline registers, in one bundle.
  typedef struct packed {
    logic pc_we;
    logic ifid_we;
    logic ifid_flush;
    logic idex_we;
    logic idex_flush;
    logic exmem_we;
    logic memwb_flush;
  } ctrl_t;
endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Load-use hazard compare: EX load whose destination feeds an ID source operand.
module load_use_detect
  import hazard_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  output logic             load_use
);
  // $zero is never a real dependency.
  assign load_use = ex_mem_read && (ex_rd != REG_ZERO) &&
                    ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer: load-use bubbles, branch/jump flushes, data-memory wait FSM with timeout.
module pipeline_hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 256,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             id_jump,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_br_taken,
  input  logic             mem_mem_read,
  input  logic             mem_mem_write,
  input  logic             dmem_ready,
  output logic             dmem_req,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_we,
  output logic             idex_flush,
  output logic             exmem_we,
  output logic             memwb_flush,
  output logic             bus_error,
  output logic [CNT_W-1:0] stall_cycles
);
  localparam logic [15:0] TO = 16'(TIMEOUT);

  state_e            state_q, state_d;
  logic [15:0]       wait_cnt_q, wait_cnt_d;
  logic              bus_err_q, bus_err_d;
  logic [CNT_W-1:0]  stall_q;
  logic              load_use, mem_acc, mstall;
  ctrl_t             ctrl;

  load_use_detect u_lud (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .load_use    (load_use)
  );

  assign mem_acc = mem_mem_read | mem_mem_write;
  assign mstall  = ((state_q == IDLE) && mem_acc && !dmem_ready) ||
                   ((state_q == WAIT) && !dmem_ready) ||
                   (state_q == ERR);

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    bus_err_d  = bus_err_q;
    case (state_q)
      IDLE: if (mem_acc && !dmem_ready) begin
        state_d    = WAIT;
        wait_cnt_d = 16'd1;
      end
      WAIT: begin
        if (dmem_ready) state_d = IDLE;
        else if (wait_cnt_q == TO) begin
          state_d   = ERR;
          bus_err_d = 1'b1;
        end else wait_cnt_d = wait_cnt_q + 16'd1;
      end
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase
  end

  // Priority mux; everything is forced low while reset is held.
  always_comb begin
    ctrl = '{pc_we: 1'b1, ifid_we: 1'b1, ifid_flush: 1'b0, idex_we: 1'b1,
             idex_flush: 1'b0, exmem_we: 1'b1, memwb_flush: 1'b0};
    if (!reset)          ctrl = '0;
    else if (mstall)     ctrl = '{pc_we: 1'b0, ifid_we: 1'b0, ifid_flush: 1'b0, idex_we: 1'b0,
                                  idex_flush: 1'b0, exmem_we: 1'b0, memwb_flush: 1'b1};
    else if (ex_br_taken) begin
      ctrl.ifid_flush = 1'b1;
      ctrl.idex_flush = 1'b1;
    end else if (load_use) begin
      ctrl.pc_we      = 1'b0;
      ctrl.ifid_we    = 1'b0;
      ctrl.idex_flush = 1'b1;
    end else if (id_jump) ctrl.ifid_flush = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      bus_err_q  <= 1'b0;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      bus_err_q  <= bus_err_d;
      if (!ctrl.pc_we && (stall_q != {CNT_W{1'b1}})) stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign dmem_req     = reset && mem_acc && (state_q != ERR);
  assign pc_we        = ctrl.pc_we;
  assign ifid_we      = ctrl.ifid_we;
  assign ifid_flush   = ctrl.ifid_flush;
  assign idex_we      = ctrl.idex_we;
  assign idex_flush   = ctrl.idex_flush;
  assign exmem_we     = ctrl.exmem_we;
  assign memwb_flush  = ctrl.memwb_flush;
  assign bus_error    = bus_err_q;
  assign stall_cycles = stall_q;
endmodule
